// File: rtl/maxnet_acc_pkg.sv
// Shared constants for the MaxNet accumulate stage: FSM encodings,
// accumulator width derivation and the activation saturation limit.
package maxnet_acc_pkg;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= v) return r;
        end
        return 31;
    endfunction

    // Largest non-negative activation representable in a WIDTH-bit signed operand.
    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/maxnet_acc_relu.sv
// relu_sat: ReLU, fixed-point rescale and saturation of a neuron's net input.
module relu_sat
    import maxnet_acc_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int FRAC  = 2,
    parameter int ACC_W = 12
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [WIDTH-1:0] res,
    output logic                    res_zero,
    output logic                    res_sat
);

    localparam logic signed [ACC_W-1:0] MAX_ACT = ACC_W'(sat_max(WIDTH));

    logic signed [ACC_W-1:0] shifted;

    function automatic logic [WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] t);
        if (t > MAX_ACT) return WIDTH'(sat_max(WIDTH));
        return t[WIDTH-1:0];
    endfunction

    assign shifted = sum >>> FRAC;

    always_comb begin
        res      = '0;
        res_zero = 1'b0;
        res_sat  = 1'b0;
        // Sign bit or exact zero means the neuron is inhibited.
        if (sum[ACC_W-1] || (sum == '0)) begin
            res_zero = 1'b1;
        end else begin
            res     = saturate(shifted);
            res_sat = (shifted > MAX_ACT);
        end
    end

endmodule

// File: rtl/maxnet_acc.sv
// MaxNet accumulate stage: sums N signed products per neuron, then applies
// ReLU/rescale/saturation and holds the activation until downstream accepts it.
module maxnet_acc
    import maxnet_acc_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int FRAC  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [2*WIDTH-1:0] prod,
    input  logic                      prod_valid,
    input  logic                      prod_last,
    output logic                      prod_ready,
    output logic        [WIDTH-1:0]   res,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_zero,
    output logic                      res_sat,
    output logic                      err
);

    localparam int CNT_W = clog2(N);
    localparam int ACC_W = 2 * WIDTH + CNT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    logic [0:0]              state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] sum_nxt;
    logic        [ACC_W-1:0] carry;
    logic        [CNT_W-1:0] cnt;
    logic                    accept;
    logic                    at_last;
    logic                    close;
    logic        [WIDTH-1:0] pp_res;
    logic                    pp_zero;
    logic                    pp_sat;

    assign prod_ready = (state == ST_ACC);
    assign res_valid  = (state == ST_HOLD);
    assign accept     = prod_valid && prod_ready;
    assign at_last    = (cnt == LAST_CNT);
    assign close      = accept && (prod_last || at_last);

    assign addend = {{(ACC_W - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};

    // Ripple of full-adder cells; carry out of the MSB is never needed
    // because ACC_W already covers the worst-case N-product sum.
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < ACC_W; i++) begin : g_fa
        assign sum_nxt[i] = acc[i] ^ addend[i] ^ carry[i];
        if (i < ACC_W - 1) begin : g_carry
            assign carry[i+1] = (acc[i] & addend[i]) | (carry[i] & (acc[i] ^ addend[i]));
        end
    end

    relu_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_relu_sat (
        .sum      (sum_nxt),
        .res      (pp_res),
        .res_zero (pp_zero),
        .res_sat  (pp_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ACC;
            acc      <= '0;
            cnt      <= '0;
            res      <= '0;
            res_zero <= 1'b0;
            res_sat  <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc <= sum_nxt;
                        cnt <= cnt + 1'b1;
                        // Closing beat: capture post-processed sum, flag any
                        // disagreement between prod_last and the beat count.
                        if (close) begin
                            state    <= ST_HOLD;
                            res      <= pp_res;
                            res_zero <= pp_zero;
                            res_sat  <= pp_sat;
                            if (prod_last != at_last) err <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_acc.sv
// Scoreboard bench for maxnet_acc: directed vectors from the test plan plus
// randomized vectors checked against an integer-arithmetic reference model.
module tb_maxnet_acc;

    localparam int WIDTH = 5;
    localparam int N     = 4;
    localparam int FRAC  = 2;
    localparam int MAXA  = (1 << (WIDTH - 1)) - 1;

    typedef struct {
        int res;
        bit zero;
        bit sat;
        bit err;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic signed [2*WIDTH-1:0] prod = '0;
    logic                      prod_valid = 1'b0;
    logic                      prod_last = 1'b0;
    logic                      prod_ready;
    logic        [WIDTH-1:0]   res;
    logic                      res_valid;
    logic                      res_ready = 1'b0;
    logic                      res_zero;
    logic                      res_sat;
    logic                      err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   err_model = 1'b0;
    int   hold_req = 0;

    maxnet_acc #(.WIDTH(WIDTH), .N(N), .FRAC(FRAC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .res        (res),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_zero   (res_zero),
        .res_sat    (res_sat),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer sum, ReLU, divide by 2^FRAC, clip.
    function automatic exp_t model(input int s, input bit e);
        exp_t r;
        int   t;
        r.err = e;
        r.res = 0; r.zero = 1'b0; r.sat = 1'b0;
        if (s <= 0) begin
            r.zero = 1'b1;
        end else begin
            t = s / (1 << FRAC);
            if (t > MAXA) begin
                r.res = MAXA; r.sat = 1'b1;
            end else begin
                r.res = t;
            end
        end
        return r;
    endfunction

    task automatic send_beat(input int v, input bit last, input bit idle_ok);
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (idle_ok && ($urandom_range(3) == 0)) begin
                prod_valid = 1'b0;
                prod       = (2*WIDTH)'($urandom);
                prod_last  = 1'b0;
            end else begin
                prod_valid = 1'b1;
                prod       = (2*WIDTH)'(v);
                prod_last  = last;
                done       = prod_ready;
            end
        end
        @(posedge clk);
    endtask

    // Sends beats until the model says the vector closes; last_at < 0 means no prod_last.
    task automatic send_vector(input int vals[$], input int last_at, input bit idle_ok);
        int  s = 0;
        bit  last;
        exp_t e;
        for (int i = 0; i < vals.size(); i++) begin
            last = (i == last_at);
            send_beat(vals[i], last, idle_ok);
            s += vals[i];
            if (last || (i == N - 1)) begin
                if (last != (i == N - 1)) err_model = 1'b1;
                e = model(s, err_model);
                sb.push_back(e);
                @(negedge clk);
                prod_valid = 1'b0;
                prod_last  = 1'b0;
                check("latency_res_valid", int'(res_valid), 1);
                break;
            end
        end
    endtask

    task automatic drain();
        int i = 0;
        while ((i < 200) && ((sb.size() != 0) || res_valid)) begin
            @(negedge clk);
            i++;
        end
        check("drain_timeout", int'((sb.size() == 0) && !res_valid), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res_valid"}, int'(res_valid), 0);
        check({tag, "_prod_ready"}, int'(prod_ready), 1);
        check({tag, "_res"}, int'(res), 0);
        check({tag, "_res_zero"}, int'(res_zero), 0);
        check({tag, "_res_sat"}, int'(res_sat), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    task automatic do_reset();
        drain();
        @(negedge clk);
        rst_n     = 1'b0;
        err_model = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per result and re-checks it every held cycle.
    initial begin
        exp_t cur;
        bit   have = 1'b0;
        int   wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have      = 1'b0;
                res_ready = 1'b0;
            end else begin
                check("prod_ready_vs_res_valid", int'(prod_ready), int'(!res_valid));
                if (res_valid) begin
                    if (!have) begin
                        if (sb.size() == 0) begin
                            check("unexpected_result", 1, 0);
                            cur = '{res: 0, zero: 1'b0, sat: 1'b0, err: 1'b0};
                        end else begin
                            cur = sb.pop_front();
                        end
                        have     = 1'b1;
                        wait_cnt = (hold_req > 0) ? hold_req : int'($urandom_range(2));
                        hold_req = 0;
                    end
                    check("res", int'(res), cur.res);
                    check("res_zero", int'(res_zero), int'(cur.zero));
                    check("res_sat", int'(res_sat), int'(cur.sat));
                    check("err", int'(err), int'(cur.err));
                    if (wait_cnt == 0) begin
                        res_ready = 1'b1;
                        have      = 1'b0;
                    end else begin
                        res_ready = 1'b0;
                        wait_cnt--;
                    end
                end else begin
                    res_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        int v[$];
        int len;
        int kind;
        int rng;

        #12;
        check_reset_outputs("init");
        @(negedge clk);
        rst_n = 1'b1;

        v = '{12, 8, -4, 4};       send_vector(v, 3, 1'b0);
        v = '{3, -10, 2, 1};       send_vector(v, 3, 1'b0);
        v = '{200, 200, 0, 0};     send_vector(v, 3, 1'b0);
        v = '{-512, -512, -512, -512}; send_vector(v, 3, 1'b0);
        drain();

        hold_req = 3;
        v = '{20, 20, 20, 20};     send_vector(v, 3, 1'b0);
        v = '{4, 4, 4, 4};         send_vector(v, 3, 1'b0);
        drain();

        // Asynchronous reset in the middle of a vector.
        send_beat(100, 1'b0, 1'b0);
        send_beat(50, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midvec");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        prod_valid = 1'b0;
        v = '{12, 8, -4, 4};       send_vector(v, 3, 1'b0);
        drain();

        v = '{8, 8};               send_vector(v, 1, 1'b0);
        v = '{12, 8, -4, 4};       send_vector(v, 3, 1'b0);
        do_reset();

        v = '{4, 4, 4, 4};         send_vector(v, -1, 1'b0);
        v = '{30, 1, 1, 1};        send_vector(v, 3, 1'b1);
        do_reset();

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(9));
            rng  = int'($urandom_range(2));
            v.delete();
            for (int i = 0; i < N; i++) begin
                if (rng == 0) v.push_back(int'($urandom_range(1023)) - 512);
                else if (rng == 1) v.push_back(int'($urandom_range(63)));
                else v.push_back(int'($urandom_range(40)) - 8);
            end
            if (kind == 0) begin
                len = int'($urandom_range(N - 2));
                send_vector(v, len, 1'b1);
            end else if (kind == 1) begin
                send_vector(v, -1, 1'b1);
            end else begin
                send_vector(v, N - 1, 1'b1);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
